// File: rtl/decode_prefix_sequencer_pkg.sv
// rtl/decode_prefix_sequencer_pkg.sv - shared types, encodings and bundle builder for the prefix sequencer
package decode_prefix_sequencer_pkg;

  typedef enum logic [2:0] {
    GRP_NONE,
    GRP_LOCK,
    GRP_REP,
    GRP_SEG,
    GRP_OPSZ,
    GRP_ADSZ
  } prefix_group_e;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_HOLD,
    ST_FAULT
  } seq_state_e;

  localparam logic [2:0] SEG_ES = 3'd0;
  localparam logic [2:0] SEG_CS = 3'd1;
  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;
  localparam logic [2:0] SEG_FS = 3'd4;
  localparam logic [2:0] SEG_GS = 3'd5;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_NE   = 2'b01;
  localparam logic [1:0] REP_E    = 2'b10;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_REPEAT = 2'b01;
  localparam logic [1:0] ERR_LENGTH = 2'b10;

  typedef struct packed {
    logic       lock;
    logic       rep_seen;
    logic [1:0] rep;
    logic       seg_seen;
    logic [2:0] seg_idx;
    logic       opsz;
    logic       adsz;
    logic [3:0] count;
  } prefix_acc_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic       operand_size;
    logic       address_size;
    logic       bus_lock;
    logic [1:0] rep;
    logic       seg_ovr;
    logic [2:0] seg_idx;
    logic [3:0] count;
    logic       error;
    logic [1:0] error_code;
  } prefix_bundle_t;

  // Size overrides flip the code-segment default rather than forcing a width.
  function automatic prefix_bundle_t make_bundle(input prefix_acc_t acc, input logic [7:0] opcode,
                                                 input logic default_size, input logic [1:0] err_code);
    prefix_bundle_t b;
    b.opcode       = opcode;
    b.operand_size = default_size ^ acc.opsz;
    b.address_size = default_size ^ acc.adsz;
    b.bus_lock     = acc.lock;
    b.rep          = acc.rep;
    b.seg_ovr      = acc.seg_seen;
    b.seg_idx      = acc.seg_idx;
    b.count        = acc.count;
    b.error        = (err_code != ERR_NONE);
    b.error_code   = err_code;
    return b;
  endfunction

endpackage

// File: rtl/decode_prefix_sequencer_if.sv
// rtl/decode_prefix_sequencer_if.sv - byte stream in, prefix bundle out
interface decode_prefix_sequencer_if;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       o_byte_ready;
  logic       o_prefix_valid;
  logic       i_prefix_ready;
  logic [7:0] o_opcode;
  logic       o_operand_size;
  logic       o_address_size;
  logic       o_bus_lock;
  logic [1:0] o_repeat;
  logic       o_segment_override;
  logic [2:0] o_segment_override_index;
  logic [3:0] o_prefix_count;
  logic       o_error;
  logic [1:0] o_error_code;

  modport slave (
    input  i_byte, i_byte_valid, i_prefix_ready,
    output o_byte_ready, o_prefix_valid, o_opcode, o_operand_size, o_address_size,
           o_bus_lock, o_repeat, o_segment_override, o_segment_override_index,
           o_prefix_count, o_error, o_error_code
  );

  modport master (
    output i_byte, i_byte_valid, i_prefix_ready,
    input  o_byte_ready, o_prefix_valid, o_opcode, o_operand_size, o_address_size,
           o_bus_lock, o_repeat, o_segment_override, o_segment_override_index,
           o_prefix_count, o_error, o_error_code
  );
endinterface

// File: rtl/decode_prefix_sequencer_classify.sv
// rtl/decode_prefix_sequencer_classify.sv - combinational byte to prefix-group classifier
module decode_prefix_sequencer_classify
  import decode_prefix_sequencer_pkg::*;
(
  input  logic [7:0]    i_byte,
  output logic          o_is_prefix,
  output prefix_group_e o_group,
  output logic [2:0]    o_seg_index,
  output logic [1:0]    o_rep_code
);

  always_comb begin
    o_group     = GRP_NONE;
    o_seg_index = SEG_ES;
    o_rep_code  = REP_NONE;
    case (i_byte)
      8'hF0: o_group = GRP_LOCK;
      8'hF2: begin o_group = GRP_REP; o_rep_code = REP_NE; end
      8'hF3: begin o_group = GRP_REP; o_rep_code = REP_E;  end
      8'h26: begin o_group = GRP_SEG; o_seg_index = SEG_ES; end
      8'h2E: begin o_group = GRP_SEG; o_seg_index = SEG_CS; end
      8'h36: begin o_group = GRP_SEG; o_seg_index = SEG_SS; end
      8'h3E: begin o_group = GRP_SEG; o_seg_index = SEG_DS; end
      8'h64: begin o_group = GRP_SEG; o_seg_index = SEG_FS; end
      8'h65: begin o_group = GRP_SEG; o_seg_index = SEG_GS; end
      8'h66: o_group = GRP_OPSZ;
      8'h67: o_group = GRP_ADSZ;
      default: ;
    endcase
    o_is_prefix = (o_group != GRP_NONE);
  end

endmodule

// File: rtl/decode_prefix_sequencer.sv
// rtl/decode_prefix_sequencer.sv - byte-serial prefix scanner feeding the opcode decode stage
module decode_prefix_sequencer
  import decode_prefix_sequencer_pkg::*;
#(
  parameter int MAX_PREFIX = 14
) (
  input logic                      clock,
  input logic                      reset_n,
  input logic                      i_flush,
  input logic                      i_default_size,
  decode_prefix_sequencer_if.slave bus
);

  localparam logic [3:0] LP_MAX_PREFIX = 4'(MAX_PREFIX);

  seq_state_e     r_state;
  prefix_acc_t    r_acc;
  prefix_bundle_t r_bundle;
  logic           r_valid;

  logic           w_is_prefix;
  prefix_group_e  w_group;
  logic [2:0]     w_seg_index;
  logic [1:0]     w_rep_code;
  logic           w_dup;
  prefix_acc_t    w_acc_next;
  logic           w_byte_ready;
  logic           w_accept;

  decode_prefix_sequencer_classify u_classify (
    .i_byte      (bus.i_byte),
    .o_is_prefix (w_is_prefix),
    .o_group     (w_group),
    .o_seg_index (w_seg_index),
    .o_rep_code  (w_rep_code)
  );

  assign w_byte_ready = reset_n && (r_state == ST_SCAN) && !i_flush;
  assign w_accept     = w_byte_ready && bus.i_byte_valid;

  // One flag per group: F2 and F3 share the REP flag, so F2 then F3 is a repeat.
  always_comb begin
    w_dup            = 1'b0;
    w_acc_next       = r_acc;
    w_acc_next.count = r_acc.count + 4'd1;
    case (w_group)
      GRP_LOCK: begin w_dup = r_acc.lock;     w_acc_next.lock = 1'b1; end
      GRP_REP:  begin
        w_dup               = r_acc.rep_seen;
        w_acc_next.rep_seen = 1'b1;
        w_acc_next.rep      = w_rep_code;
      end
      GRP_SEG:  begin
        w_dup               = r_acc.seg_seen;
        w_acc_next.seg_seen = 1'b1;
        w_acc_next.seg_idx  = w_seg_index;
      end
      GRP_OPSZ: begin w_dup = r_acc.opsz;     w_acc_next.opsz = 1'b1; end
      GRP_ADSZ: begin w_dup = r_acc.adsz;     w_acc_next.adsz = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_SCAN;
      r_acc    <= '0;
      r_bundle <= '0;
      r_valid  <= 1'b0;
    end else if (i_flush) begin
      r_state  <= ST_SCAN;
      r_acc    <= '0;
      r_bundle <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_accept) begin
            if (!w_is_prefix) begin
              r_bundle <= make_bundle(r_acc, bus.i_byte, i_default_size, ERR_NONE);
              r_valid  <= 1'b1;
              r_state  <= ST_HOLD;
            end else if (w_dup) begin
              r_bundle <= make_bundle(r_acc, 8'h00, i_default_size, ERR_REPEAT);
              r_valid  <= 1'b1;
              r_state  <= ST_FAULT;
            end else if (r_acc.count == LP_MAX_PREFIX) begin
              r_bundle <= make_bundle(r_acc, 8'h00, i_default_size, ERR_LENGTH);
              r_valid  <= 1'b1;
              r_state  <= ST_FAULT;
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end
        ST_HOLD, ST_FAULT: begin
          if (bus.i_prefix_ready) begin
            r_state  <= ST_SCAN;
            r_acc    <= '0;
            r_bundle <= '0;
            r_valid  <= 1'b0;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign bus.o_byte_ready             = w_byte_ready;
  assign bus.o_prefix_valid           = r_valid;
  assign bus.o_opcode                 = r_bundle.opcode;
  assign bus.o_operand_size           = r_bundle.operand_size;
  assign bus.o_address_size           = r_bundle.address_size;
  assign bus.o_bus_lock               = r_bundle.bus_lock;
  assign bus.o_repeat                 = r_bundle.rep;
  assign bus.o_segment_override       = r_bundle.seg_ovr;
  assign bus.o_segment_override_index = r_bundle.seg_idx;
  assign bus.o_prefix_count           = r_bundle.count;
  assign bus.o_error                  = r_bundle.error;
  assign bus.o_error_code             = r_bundle.error_code;

endmodule
